lc3_fetch_stage: RTL and testbench
==================================

// Module: lc3_fetch_stage
// PURPOSE
//  LC3 fetch stage: holds the PC, issues instruction-memory reads, tracks reads in flight and
//  presents each returned instruction with its next-PC to the decode stage (dout, npc_out,
//  enable_decode). Sits between the controller/execute branch path and lc3 decode. Supports a
//  fixed-latency instruction memory and squashes wrong-path reads on a branch redirect.
// PARAMETERS
//  PC_RESET      16'h3000  PC value loaded on reset
//  IMEM_LATENCY  1         cycles from instrmem_rd strobe to valid imem_dout; legal 1..3
// PORTS
//  clock            in   1   single clock; all state updates on posedge
//  reset            in   1   synchronous, active-high
//  enable_fetch     in   1   controller permits an imem read this cycle
//  enable_updatePC  in   1   controller permits a PC update this cycle
//  br_taken         in   1   redirect request; honoured only with enable_updatePC
//  taddr            in   16  redirect target
//  pc               out  16  imem read address (registered)
//  instrmem_rd      out  1   imem read strobe (combinational)
//  imem_dout        in   16  instruction returned IMEM_LATENCY cycles after the strobe
//  dout             out  16  instruction to decode
//  npc_out          out  16  PC+1 of the instruction on dout
//  enable_decode    out  1   dout/npc_out valid this cycle
// BEHAVIOUR
//  - Reset (sync, wins over everything): pc=PC_RESET, dout=0, npc_out=0, enable_decode=0,
//    all in-flight tags cleared. instrmem_rd = enable_fetch & ~reset, so 0 during reset.
//  - PC update at posedge: redirect = br_taken & enable_updatePC -> pc<=taddr;
//    else enable_updatePC -> pc<=pc+1; else hold. br_taken without enable_updatePC ignored.
//  - Arithmetic modulo 2^16: pc 16'hFFFF +1 -> 16'h0000; npc for pc=FFFF is 0000.
//  - Issue: instrmem_rd=1 in cycle N pushes tag {valid=1, npc=pc+1} into an IMEM_LATENCY-deep
//    shift register; cycles without issue push valid=0. Shift every cycle, never stalls.
//  - Return: tag at depth IMEM_LATENCY aligns with imem_dout in cycle N+IMEM_LATENCY.
//    If valid: at that posedge dout<=imem_dout, npc_out<=tag.npc, enable_decode<=1.
//    If not valid: enable_decode<=0, dout/npc_out hold previous values.
//  - Latency: strobe cycle N -> enable_decode high in cycle N+IMEM_LATENCY+1.
//  - Squash: a redirect clears valid on every in-flight tag, including the tag pushed in the
//    redirect cycle; the returning tag in the redirect cycle is also dropped. First post-redirect
//    fetch is from taddr, delivered with npc_out=taddr+1.
//  - Stall: enable_fetch=0 issues nothing; pipeline drains, enable_decode falls once empty.
//    enable_updatePC=1 with enable_fetch=0 advances pc with no read (controller-defined skip).
//  - Reset mid-operation: pending reads never reach decode; imem_dout ignored until a new
//    strobe after reset deasserts; first enable_decode no earlier than IMEM_LATENCY+1 cycles later.
//  - Back-to-back issue every cycle yields enable_decode high every cycle (full throughput).
//  - No X on outputs after the first reset edge.
// STRUCTURE
//  - Shared package lc3_types_pkg: typedef logic [15:0] word_t; PC_RESET_DEFAULT;
//    typedef struct packed {logic valid; word_t npc;} fetch_tag_t.
//  - Sub-module lc3_fetch_tag_pipe: parameterised fetch_tag_t shift register (depth
//    IMEM_LATENCY) with push, squash-all and synchronous clear.
//  - Top holds PC register, redirect mux, output registers; elaboration check on IMEM_LATENCY.
// TESTING
//  1 Reset 3 cycles, enable_fetch=1 -> pc=3000, instrmem_rd=0, enable_decode=0, dout=0, npc_out=0.
//  2 L=1, enable_fetch=enable_updatePC=1 x4, imem returns 16'h1000|pc[7:0] -> enable_decode high
//    from 2 cycles after first strobe, dout 1000,1001,1002,1003, npc_out 3001..3004.
//  3 Redirect br_taken=1,taddr=3100 when pc=3002 (L=2) -> next pc=3100; reads of 3001,3002 never
//    reach decode; next enable_decode shows npc_out=3101.
//  4 enable_fetch=enable_updatePC=0 for 4 cycles -> pc holds, enable_decode low after drain,
//    dout/npc_out hold last values; resume -> delivery restarts with no gap or duplicate.
//  5 Redirect taddr=FFFF, run 2 fetches -> pc FFFF then 0000; npc_out 0000 then 0001.
//  6 L=3, reset asserted with 3 reads in flight -> no enable_decode pulse for them; first
//    post-reset fetch returns npc_out=3001.

Source files
------------

// File: rtl/lc3_types_pkg.sv
// Shared LC3 fetch-path types.
//   word_t           16-bit LC3 machine word (addresses and instructions)
//   PC_RESET_DEFAULT PC value loaded on reset unless overridden
//   fetch_tag_t      bookkeeping carried alongside an outstanding imem read
//   TAG_EMPTY        tag value for an empty pipeline slot
//   pc_incr()        PC+1, wrapping modulo 2^16
package lc3_types_pkg;

  typedef logic [15:0] word_t;

  localparam word_t PC_RESET_DEFAULT = 16'h3000;

  typedef struct packed {
    logic  valid;
    word_t npc;
  } fetch_tag_t;

  localparam fetch_tag_t TAG_EMPTY = '{valid: 1'b0, npc: 16'h0000};

  function automatic word_t pc_incr(input word_t pc_val);
    return pc_val + 16'd1;
  endfunction

endpackage

// File: rtl/lc3_fetch_tag_pipe.sv
// Fixed-depth shift register of fetch tags, one slot per cycle of imem latency.
//   clk_i    clock
//   rst_i    synchronous active-high clear of every slot
//   push_i   a read is issued this cycle (enters slot 0 as valid)
//   npc_i    next-PC recorded with the issued read
//   squash_i invalidate every slot, including the one being pushed
//   tag_o    oldest slot; lines up with the imem data for that read
module lc3_fetch_tag_pipe
  import lc3_types_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       push_i,
  input  word_t      npc_i,
  input  logic       squash_i,
  output fetch_tag_t tag_o
);

  fetch_tag_t pipe_q [DEPTH];
  fetch_tag_t pipe_d [DEPTH];

  always_comb begin
    for (int i = 0; i < DEPTH; i++) pipe_d[i] = pipe_q[i];
    // A slot is written every cycle; idle cycles insert a bubble.
    pipe_d[0] = '{valid: push_i, npc: npc_i};
    for (int i = 1; i < DEPTH; i++) pipe_d[i] = pipe_q[i-1];
    if (squash_i) begin
      for (int i = 0; i < DEPTH; i++) pipe_d[i].valid = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) pipe_q[i] <= TAG_EMPTY;
    end else begin
      pipe_q <= pipe_d;
    end
  end

  assign tag_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/lc3_fetch_stage.sv
// LC3 fetch stage: owns the PC, strobes instruction-memory reads, tracks the
// reads in flight and hands each returned instruction plus its next-PC to
// decode. A taken branch redirects the PC and discards every wrong-path read.
//   clock            single clock, posedge
//   reset            synchronous, active-high
//   enable_fetch     controller allows an imem read this cycle
//   enable_updatePC  controller allows a PC update this cycle
//   br_taken/taddr   redirect request and target (only with enable_updatePC)
//   pc               registered imem read address
//   instrmem_rd      imem read strobe (combinational)
//   imem_dout        instruction returned IMEM_LATENCY cycles after strobe
//   dout/npc_out     instruction and its PC+1 for decode
//   enable_decode    dout/npc_out valid this cycle
module lc3_fetch_stage
  import lc3_types_pkg::*;
#(
  parameter logic [15:0] PC_RESET     = PC_RESET_DEFAULT,
  parameter int          IMEM_LATENCY = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable_fetch,
  input  logic        enable_updatePC,
  input  logic        br_taken,
  input  logic [15:0] taddr,
  output logic [15:0] pc,
  output logic        instrmem_rd,
  input  logic [15:0] imem_dout,
  output logic [15:0] dout,
  output logic [15:0] npc_out,
  output logic        enable_decode
);

  if (IMEM_LATENCY < 1 || IMEM_LATENCY > 3) begin : g_bad_latency
    $error("lc3_fetch_stage: IMEM_LATENCY must be in 1..3");
  end

  word_t      pc_q, pc_d;
  word_t      dout_q, dout_d;
  word_t      npc_q, npc_d;
  logic       dec_q, dec_d;
  logic       redirect;
  word_t      pc_seq;
  fetch_tag_t ret_tag;

  assign instrmem_rd = enable_fetch & ~reset;
  assign redirect    = br_taken & enable_updatePC;
  assign pc_seq      = pc_incr(pc_q);

  always_comb begin
    pc_d = pc_q;
    if (redirect) begin
      pc_d = taddr;
    end else if (enable_updatePC) begin
      pc_d = pc_seq;
    end
  end

  // Issue -> return: tags ride a latency-deep pipe alongside the imem read.
  lc3_fetch_tag_pipe #(
    .DEPTH (IMEM_LATENCY)
  ) u_tag_pipe (
    .clk_i    (clock),
    .rst_i    (reset),
    .push_i   (instrmem_rd),
    .npc_i    (pc_seq),
    .squash_i (redirect),
    .tag_o    (ret_tag)
  );

  // Return -> decode: the read returning in a redirect cycle is wrong-path too.
  always_comb begin
    dout_d = dout_q;
    npc_d  = npc_q;
    dec_d  = 1'b0;
    if (ret_tag.valid && !redirect) begin
      dout_d = imem_dout;
      npc_d  = ret_tag.npc;
      dec_d  = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q   <= PC_RESET;
      dout_q <= '0;
      npc_q  <= '0;
      dec_q  <= 1'b0;
    end else begin
      pc_q   <= pc_d;
      dout_q <= dout_d;
      npc_q  <= npc_d;
      dec_q  <= dec_d;
    end
  end

  assign pc            = pc_q;
  assign dout          = dout_q;
  assign npc_out       = npc_q;
  assign enable_decode = dec_q;

endmodule

// File: tb/tb_lc3_fetch_stage.sv
`timescale 1ns/1ps
module tb_lc3_fetch_stage;

  localparam int NI = 3;   // instance i has IMEM_LATENCY = i+1

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        enable_fetch = 1'b0;
  logic        enable_updatePC = 1'b0;
  logic        br_taken = 1'b0;
  logic [15:0] taddr = 16'h0000;

  logic [15:0] pc_a   [NI];
  logic        rd_a   [NI];
  logic [15:0] imem_a [NI];
  logic [15:0] dout_a [NI];
  logic [15:0] npc_a  [NI];
  logic        dec_a  [NI];

  always #5 clock = ~clock;

  lc3_fetch_stage #(.PC_RESET(16'h3000), .IMEM_LATENCY(1)) u_l1 (
    .clock(clock), .reset(reset), .enable_fetch(enable_fetch),
    .enable_updatePC(enable_updatePC), .br_taken(br_taken), .taddr(taddr),
    .pc(pc_a[0]), .instrmem_rd(rd_a[0]), .imem_dout(imem_a[0]),
    .dout(dout_a[0]), .npc_out(npc_a[0]), .enable_decode(dec_a[0]));

  lc3_fetch_stage #(.PC_RESET(16'h3000), .IMEM_LATENCY(2)) u_l2 (
    .clock(clock), .reset(reset), .enable_fetch(enable_fetch),
    .enable_updatePC(enable_updatePC), .br_taken(br_taken), .taddr(taddr),
    .pc(pc_a[1]), .instrmem_rd(rd_a[1]), .imem_dout(imem_a[1]),
    .dout(dout_a[1]), .npc_out(npc_a[1]), .enable_decode(dec_a[1]));

  lc3_fetch_stage #(.PC_RESET(16'h3000), .IMEM_LATENCY(3)) u_l3 (
    .clock(clock), .reset(reset), .enable_fetch(enable_fetch),
    .enable_updatePC(enable_updatePC), .br_taken(br_taken), .taddr(taddr),
    .pc(pc_a[2]), .instrmem_rd(rd_a[2]), .imem_dout(imem_a[2]),
    .dout(dout_a[2]), .npc_out(npc_a[2]), .enable_decode(dec_a[2]));

  // Instruction memory contents.
  function automatic logic [15:0] imem_word(input logic [15:0] a);
    return 16'h1000 | {8'h00, a[7:0]};
  endfunction

  // Fixed-latency memory: answers a strobe L cycles later, garbage otherwise.
  logic [15:0] dsh [NI][3];
  always @(posedge clock) begin
    for (int i = 0; i < NI; i++) begin
      dsh[i][2] <= dsh[i][1];
      dsh[i][1] <= dsh[i][0];
      dsh[i][0] <= rd_a[i] ? imem_word(pc_a[i]) : 16'($urandom);
    end
  end
  always_comb begin
    for (int i = 0; i < NI; i++) imem_a[i] = dsh[i][i];
  end

  // Reference model and scoreboard.
  typedef struct {
    logic [15:0] data;
    logic [15:0] npc;
    int          due;
  } exp_t;

  exp_t        sbq [NI][$];
  logic [15:0] last_d [NI];
  logic [15:0] last_n [NI];
  logic [15:0] mdl_pc = 16'h0000;
  int          edge_n = 0;
  logic        started = 1'b0;
  int          n_checks = 0;
  int          n_pass = 0;

  task automatic chk(input string nm, input int inst,
                     input logic [15:0] act, input logic [15:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s [L=%0d] edge=%0d actual=%h required=%h",
                  nm, inst + 1, edge_n, act, req);
  endtask

  // One clock cycle of stimulus; the model absorbs the edge that consumes it.
  task automatic cyc(input logic r, input logic ef, input logic eu,
                     input logic bt, input logic [15:0] ta);
    exp_t e;
    reset = r; enable_fetch = ef; enable_updatePC = eu;
    br_taken = bt; taddr = ta;
    @(posedge clock);
    edge_n++;
    if (r) begin
      mdl_pc = 16'h3000;
      for (int i = 0; i < NI; i++) begin
        sbq[i].delete();
        last_d[i] = 16'h0000;
        last_n[i] = 16'h0000;
      end
      started = 1'b1;
    end else begin
      if (bt && eu) begin
        for (int i = 0; i < NI; i++) sbq[i].delete();
      end else if (ef) begin
        for (int i = 0; i < NI; i++) begin
          e.data = imem_word(mdl_pc);
          e.npc  = mdl_pc + 16'd1;
          e.due  = edge_n + i + 1;
          sbq[i].push_back(e);
        end
      end
      if (bt && eu)  mdl_pc = ta;
      else if (eu)   mdl_pc = mdl_pc + 16'd1;
    end
    #1;
  endtask

  // Monitor: every cycle compare PC/strobe, and pop a delivery when one is due.
  always @(negedge clock) begin : mon
    exp_t e;
    if (started) begin
      for (int i = 0; i < NI; i++) begin
        chk("pc", i, pc_a[i], mdl_pc);
        chk("instrmem_rd", i, {15'd0, rd_a[i]}, {15'd0, enable_fetch & ~reset});
        if (sbq[i].size() > 0 && sbq[i][0].due == edge_n) begin
          e = sbq[i].pop_front();
          chk("enable_decode", i, {15'd0, dec_a[i]}, 16'd1);
          chk("dout", i, dout_a[i], e.data);
          chk("npc_out", i, npc_a[i], e.npc);
          last_d[i] = e.data;
          last_n[i] = e.npc;
        end else begin
          chk("enable_decode_idle", i, {15'd0, dec_a[i]}, 16'd0);
          chk("dout_hold", i, dout_a[i], last_d[i]);
          chk("npc_out_hold", i, npc_a[i], last_n[i]);
        end
      end
    end
  end

  initial begin
    logic r, ef, eu, bt;
    logic [15:0] ta;

    // Reset with fetch requested: strobe must stay low.
    repeat (3) cyc(1, 1, 0, 0, 16'h0000);
    // Straight-line fetch.
    repeat (6) cyc(0, 1, 1, 0, 16'h0000);
    // Fresh start, then redirect while pc = 3002.
    repeat (2) cyc(1, 0, 0, 0, 16'h0000);
    repeat (2) cyc(0, 1, 1, 0, 16'h0000);
    cyc(0, 1, 1, 1, 16'h3100);
    repeat (4) cyc(0, 1, 1, 0, 16'h0000);
    // Stall, drain, resume.
    repeat (4) cyc(0, 0, 0, 0, 16'h0000);
    repeat (4) cyc(0, 1, 1, 0, 16'h0000);
    // br_taken without enable_updatePC is ignored.
    cyc(0, 1, 0, 1, 16'h5555);
    // Redirect to the top of memory and wrap.
    cyc(0, 1, 1, 1, 16'hFFFF);
    repeat (3) cyc(0, 1, 1, 0, 16'h0000);
    // PC skip without a read.
    repeat (2) cyc(0, 0, 1, 0, 16'h0000);
    repeat (4) cyc(0, 0, 0, 0, 16'h0000);
    // Reset with reads in flight.
    repeat (3) cyc(0, 1, 1, 0, 16'h0000);
    repeat (2) cyc(1, 1, 1, 0, 16'h0000);
    repeat (5) cyc(0, 1, 1, 0, 16'h0000);

    // Randomised traffic.
    for (int k = 0; k < 400; k++) begin
      r  = ($urandom_range(0, 59) == 0);
      ef = ($urandom_range(0, 3) != 0);
      eu = ($urandom_range(0, 3) != 0);
      bt = ($urandom_range(0, 7) == 0);
      ta = ($urandom_range(0, 3) == 0) ? 16'hFFFE + 16'($urandom_range(0, 1))
                                       : 16'($urandom);
      cyc(r, ef, eu, bt, ta);
    end

    // Drain and confirm nothing was left undelivered.
    repeat (6) cyc(0, 0, 0, 0, 16'h0000);
    for (int i = 0; i < NI; i++) chk("drained", i, 16'(sbq[i].size()), 16'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
